// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, access-size encodings and FSM states for the LSU initiator
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } lsu_state_e;

endpackage

// File: rtl/lsu_decode.sv
// rtl/lsu_decode.sv - funct3/op/address decode into access size, signedness and fault flags
module lsu_decode
   import lsu_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic       is_store_i,
   input  logic [1:0] addr_lo_i,
   output logic [1:0] access_size_o,
   output logic       is_signed_o,
   output logic       illegal_o,
   output logic       misaligned_o
);

   always_comb begin
      access_size_o = SIZE_BYTE;
      is_signed_o   = 1'b0;
      illegal_o     = 1'b0;
      case (funct3_i)
         F3_B:  is_signed_o = 1'b1;
         F3_H: begin
            access_size_o = SIZE_HALF;
            is_signed_o   = 1'b1;
         end
         F3_W:  access_size_o = SIZE_WORD;
         F3_BU: illegal_o = is_store_i;
         F3_HU: begin
            access_size_o = SIZE_HALF;
            illegal_o     = is_store_i;
         end
         default: illegal_o = 1'b1;
      endcase
      misaligned_o = ((access_size_o == SIZE_HALF) && addr_lo_i[0]) ||
                     ((access_size_o == SIZE_WORD) && (addr_lo_i != 2'b00));
   end

endmodule

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - single-outstanding load/store initiator driving a byte-addressed data memory
module lsu_mem_initiator
   import lsu_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_base,
   input  logic [ADDR_W-1:0] req_offset,
   input  logic [31:0]       req_store_data,
   input  logic [4:0]        req_rd,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_data,
   output logic [4:0]        resp_rd,
   output logic [ADDR_W-1:0] resp_addr,
   output logic              resp_misaligned,
   output logic              resp_illegal,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_data_in,
   output logic              mem_read_write,
   output logic [1:0]        mem_access_size,
   output logic              mem_is_signed,
   input  logic [31:0]       mem_data_out
);

   localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic              store_q, store_d;
   logic              mis_q, mis_d;
   logic              ill_q, ill_d;
   logic [31:0]       sdata_q, sdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [4:0]        rd_q, rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [ADDR_W-1:0] eff_addr;
   logic [1:0]        dec_size;
   logic              dec_signed, dec_illegal, dec_misaligned;
   logic              in_access;

   assign eff_addr = req_base + req_offset;

   lsu_decode u_decode (
      .funct3_i      (req_funct3),
      .is_store_i    (req_is_store),
      .addr_lo_i     (eff_addr[1:0]),
      .access_size_o (dec_size),
      .is_signed_o   (dec_signed),
      .illegal_o     (dec_illegal),
      .misaligned_o  (dec_misaligned)
   );

   assign req_ready = reset_n && (state_q == ST_IDLE);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      size_d   = size_q;
      signed_d = signed_q;
      store_d  = store_q;
      mis_d    = mis_q;
      ill_d    = ill_q;
      sdata_d  = sdata_q;
      rdata_d  = rdata_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               addr_d   = eff_addr;
               size_d   = dec_size;
               signed_d = dec_signed;
               store_d  = req_is_store;
               sdata_d  = req_store_data;
               rd_d     = req_rd;
               rdata_d  = '0;
               ill_d    = dec_illegal;
               // illegal takes precedence when both faults apply
               mis_d    = dec_misaligned && !dec_illegal;
               cnt_d    = CNT_W'(WAIT_STATES);
               state_d  = (dec_illegal || dec_misaligned) ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               if (!store_q) rdata_d = mem_data_out;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         store_q  <= 1'b0;
         mis_q    <= 1'b0;
         ill_q    <= 1'b0;
         sdata_q  <= '0;
         rdata_q  <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         store_q  <= store_d;
         mis_q    <= mis_d;
         ill_q    <= ill_d;
         sdata_q  <= sdata_d;
         rdata_q  <= rdata_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
      end
   end

   assign resp_valid      = (state_q == ST_RESP);
   assign resp_data       = rdata_q;
   assign resp_rd         = rd_q;
   assign resp_addr       = addr_q;
   assign resp_misaligned = mis_q;
   assign resp_illegal    = ill_q;

   // Memory port is gated by state, so reset drops the write strobe without waiting for a clock
   assign in_access       = (state_q == ST_ACCESS);
   assign mem_address     = in_access ? addr_q : '0;
   assign mem_data_in     = in_access ? sdata_q : '0;
   assign mem_access_size = in_access ? size_q : '0;
   assign mem_is_signed   = in_access && signed_q;
   assign mem_read_write  = in_access && store_q && (cnt_q == '0);

endmodule
